jtag_l2_burst_adapter: RTL and testbench
========================================

// Module: jtag_l2_burst_adapter
// PURPOSE
//  Downstream stage of the JTAG debug bridge in jtagL2test.
//  Turns word-burst commands (addr, len, we) and write beats from the bridge's clk_i-side
//  port into single-word TCDM requests to the L2 SRAM bank.
//  Returns read beats through a small FIFO and signals burst completion with a response pulse.
// PARAMETERS
//  ADDR_W        32            byte address width
//  RD_FIFO_DEPTH 2             read-return FIFO entries; also max in-flight reads (>=1)
//  L2_BASE       32'h0000_0000 L2 window base, byte address (used only with check enabled)
//  L2_SIZE       32'h0008_0000 L2 window size in bytes (used only with check enabled)
// PORTS
//  clk_i          in   1       clock
//  rst_n          in   1       reset, synchronous, active-low
//  cmd_valid_i    in   1       burst command valid
//  cmd_ready_o    out  1       command accepted when valid&ready
//  cmd_we_i       in   1       1=write burst, 0=read burst
//  cmd_addr_i     in   ADDR_W  start byte address
//  cmd_len_i      in   8       beats-1 (0 -> 1 word, 255 -> 256 words)
//  wdata_valid_i  in   1       write beat valid
//  wdata_ready_o  out  1       write beat consumed
//  wdata_i        in   32      write beat data
//  rdata_valid_o  out  1       read beat valid (FIFO head)
//  rdata_ready_i  in   1       read beat popped
//  rdata_o        out  32      read beat data
//  resp_valid_o   out  1       one-cycle pulse: burst finished
//  resp_err_o     out  1       error flag, qualified by resp_valid_o
//  l2_req_o       out  1       TCDM request
//  l2_gnt_i       in   1       TCDM grant
//  l2_addr_o      out  ADDR_W  word address << 2, bits[1:0]=0
//  l2_we_o        out  1       TCDM write enable
//  l2_be_o        out  4       byte enables, always 4'hF
//  l2_wdata_o     out  32      TCDM write data (= wdata_i)
//  l2_rvalid_i    in   1       read data valid, exactly 1 cycle after gnt
//  l2_rdata_i     in   32      read data
// BEHAVIOUR
//  Reset values: cmd_ready_o=0 during reset, then 1 in IDLE.
//   All other outputs are 0 during reset.
//   Reset flushes the FIFO and clears the FSM, counters and outstanding count.
//  FSM states: IDLE -> WRITE | READ -> RESP -> IDLE.
//  IDLE: cmd_ready_o=1. On a command handshake, latch addr (bits[1:0] cleared), we and cnt=len.
//   Go to WRITE (we=1) or READ (we=0) on the next cycle.
//  WRITE: l2_req_o=wdata_valid_i, l2_we_o=1, wdata_ready_o=l2_gnt_i (combinational).
//   Each grant: addr+=4, cnt-=1. The grant with cnt==0 -> RESP.
//   Upstream holds wdata_valid_i/wdata_i stable until wdata_ready_o.
//  READ: l2_req_o=1 while issued<=len and (in_flight+fifo_count)<RD_FIFO_DEPTH. l2_we_o=0.
//   Each grant: addr+=4, in_flight+=1.
//   Each l2_rvalid_i: push into FIFO, in_flight-=1. A rvalid with in_flight==0 is ignored.
//   The FIFO is never overrun: push and pop in the same cycle are both taken.
//   -> RESP after the len+1-th beat is popped.
//  RESP: resp_valid_o=1 for exactly one cycle -> IDLE. cmd_ready_o=0 in RESP.
//  Latency: first TCDM request appears 1 cycle after the command handshake.
//   Read data reaches rdata_o 1 cycle after l2_rvalid_i.
//  Address arithmetic is modulo 2^ADDR_W; a burst past 0xFFFF_FFFC wraps to 0x0.
//  Reset mid-burst: l2_req_o is 0 from the first reset cycle. No rdata_valid_o or resp_valid_o
//   for the aborted burst. Late rvalid is ignored.
//  Commands arriving outside IDLE are not accepted. Exactly one burst is active at a time.
// CONFIGURATION
//  JTAG_L2_ADDR_CHECK_EN defined:
//   A command is in error if addr[1:0]!=0 or [addr, addr+4*(len+1)) is not inside
//   [L2_BASE, L2_BASE+L2_SIZE). An erroring command issues no TCDM requests.
//   Error write: beats are consumed and discarded, wdata_ready_o=wdata_valid_i.
//   Error read: len+1 beats of 32'hDEAD_BEEF are returned via the FIFO.
//   RESP then drives resp_err_o=1.
//  JTAG_L2_ADDR_CHECK_EN undefined:
//   addr[1:0] is silently cleared, no range check, resp_err_o is tied to 0.
//   L2_BASE and L2_SIZE are unused.
// TESTING
//  T1 write 0x0 len0 data 32'hABBAABBA, gnt same cycle
//     -> one req, addr 0x0, we=1, be=F, resp pulse, err=0.
//     Then read 0x0 len0 -> rdata 32'hABBAABBA, resp err=0.
//  T2 write 0x100 len3, gnt low 2 cycles per beat
//     -> addresses 0x100, 0x104, 0x108, 0x10C in order, 4 beats, no drop or duplicate.
//  T3 read 0x200 len7, rdata_ready_i=0 for 20 cycles -> exactly RD_FIFO_DEPTH grants, then
//     l2_req_o=0. Release -> 8 words in address order, one resp pulse.
//  T4 rst_n=0 for 1 cycle after 2 read grants -> next cycle l2_req_o=0, cmd_ready_o=1.
//     Late rvalid is dropped, rdata_valid_o stays 0.
//  T5 read addr 0xFFFF_FFFC len1, macro undefined -> req addresses 0xFFFF_FFFC then 0x0.
//  T6 macro defined: read L2_BASE+L2_SIZE-4 len1 -> zero l2_req, 2 beats 32'hDEAD_BEEF, err=1.
//     Write addr 0x2 len0 -> beat consumed, no req, err=1.

Source files
------------

// File: rtl/jtag_l2_burst_adapter.sv
// JTAG L2 burst adapter: splits bridge word bursts into single-word TCDM accesses.
// Optional window/alignment checking is compiled in with JTAG_L2_ADDR_CHECK_EN.
module jtag_l2_burst_adapter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned RD_FIFO_DEPTH = 2,
    parameter logic [31:0] L2_BASE       = 32'h0000_0000,
    parameter logic [31:0] L2_SIZE       = 32'h0008_0000
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [7:0]        cmd_len_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [31:0]       wdata_i,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [31:0]       rdata_o,
    output logic              resp_valid_o,
    output logic              resp_err_o,
    output logic              l2_req_o,
    input  logic              l2_gnt_i,
    output logic [ADDR_W-1:0] l2_addr_o,
    output logic              l2_we_o,
    output logic [3:0]        l2_be_o,
    output logic [31:0]       l2_wdata_o,
    input  logic              l2_rvalid_i,
    input  logic [31:0]       l2_rdata_i
);

    localparam int unsigned PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RD_FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [CNT_W:0]    DEPTH_W   = (CNT_W+1)'(RD_FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(RD_FIFO_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RD_FIFO_DEPTH - 1);
    localparam logic [31:0]       ERR_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [8:0]        r_issued;
    logic [8:0]        r_popped;
    logic              r_err;
    logic [CNT_W-1:0]  r_in_flight;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [31:0]       r_mem [RD_FIFO_DEPTH];

    logic              w_cmd_hs;
    logic              w_cmd_err;
    logic              w_more;
    logic              w_room;
    logic              w_wbeat;
    logic              w_rgnt;
    logic              w_err_push;
    logic              w_issue;
    logic              w_rv;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pop;
    logic [31:0]       w_push_data;

`ifdef JTAG_L2_ADDR_CHECK_EN
    localparam int unsigned EXT_W = ((ADDR_W > 32) ? ADDR_W : 32) + 2;

    logic [EXT_W-1:0] w_beg;
    logic [EXT_W-1:0] w_end;
    logic [EXT_W-1:0] w_lo;
    logic [EXT_W-1:0] w_hi;

    // Widened so the end-of-burst bound cannot wrap around the address space.
    assign w_beg     = EXT_W'(cmd_addr_i);
    assign w_end     = w_beg + EXT_W'({cmd_len_i, 2'b00}) + EXT_W'(4);
    assign w_lo      = EXT_W'(L2_BASE);
    assign w_hi      = w_lo + EXT_W'(L2_SIZE);
    assign w_cmd_err = (cmd_addr_i[1:0] != 2'b00) | (w_beg < w_lo) | (w_end > w_hi);
`else
    assign w_cmd_err = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_cmd_hs    = cmd_valid_i & cmd_ready_o;
    assign w_more      = r_issued <= {1'b0, r_len};
    assign w_room      = ({1'b0, r_in_flight} + {1'b0, r_count}) < DEPTH_W;
    assign w_rv        = rst_n & l2_rvalid_i & (r_in_flight != '0);
    assign w_push      = w_err_push | w_rv;
    assign w_push_data = r_err ? ERR_DATA : l2_rdata_i;
    assign w_issue     = w_rgnt | w_err_push;
    assign w_pop       = rdata_valid_o & rdata_ready_i;
    assign w_last_pop  = w_pop & (r_popped == {1'b0, r_len});

    assign rdata_valid_o = rst_n & (r_count != '0);
    assign rdata_o       = rst_n ? r_mem[r_rptr] : 32'h0;
    assign resp_err_o    = resp_valid_o & r_err;
    assign l2_addr_o     = rst_n ? r_addr : '0;
    assign l2_be_o       = rst_n ? 4'hF : 4'h0;
    assign l2_wdata_o    = rst_n ? wdata_i : 32'h0;

    always_comb begin
        w_state_nxt   = r_state;
        cmd_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        l2_req_o      = 1'b0;
        l2_we_o       = 1'b0;
        resp_valid_o  = 1'b0;
        w_wbeat       = 1'b0;
        w_rgnt        = 1'b0;
        w_err_push    = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                S_IDLE: begin
                    cmd_ready_o = 1'b1;
                    if (cmd_valid_i) begin
                        w_state_nxt = cmd_we_i ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (r_err) begin
                        wdata_ready_o = wdata_valid_i;
                        w_wbeat       = wdata_valid_i;
                    end else begin
                        l2_req_o      = wdata_valid_i;
                        l2_we_o       = 1'b1;
                        wdata_ready_o = l2_gnt_i;
                        w_wbeat       = wdata_valid_i & l2_gnt_i;
                    end
                    if (w_wbeat && (r_cnt == 8'd0)) begin
                        w_state_nxt = S_RESP;
                    end
                end
                S_READ: begin
                    // Errored reads feed filler beats straight into the FIFO.
                    if (r_err) begin
                        w_err_push = w_more & (r_count < DEPTH_C);
                    end else begin
                        l2_req_o = w_more & w_room;
                        w_rgnt   = l2_req_o & l2_gnt_i;
                    end
                    if (w_last_pop) begin
                        w_state_nxt = S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid_o = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= 8'd0;
            r_cnt       <= 8'd0;
            r_issued    <= 9'd0;
            r_popped    <= 9'd0;
            r_err       <= 1'b0;
            r_in_flight <= '0;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_hs) begin
                r_addr   <= cmd_addr_i & ADDR_MASK;
                r_len    <= cmd_len_i;
                r_cnt    <= cmd_len_i;
                r_issued <= 9'd0;
                r_popped <= 9'd0;
                r_err    <= w_cmd_err;
            end
            if (w_wbeat) begin
                r_addr <= r_addr + ADDR_W'(4);
                r_cnt  <= r_cnt - 8'd1;
            end
            if (w_rgnt) begin
                r_addr <= r_addr + ADDR_W'(4);
            end
            if (w_issue) begin
                r_issued <= r_issued + 9'd1;
            end
            if (w_pop) begin
                r_popped <= r_popped + 9'd1;
                r_rptr   <= ptr_inc(r_rptr);
            end
            if (w_rgnt && !w_rv) begin
                r_in_flight <= r_in_flight + CNT_W'(1);
            end else if (!w_rgnt && w_rv) begin
                r_in_flight <= r_in_flight - CNT_W'(1);
            end
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is visible.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

endmodule

// File: tb/tb_jtag_l2_burst_adapter.sv
// Scoreboard bench for jtag_l2_burst_adapter: random bursts against a word-memory model.
// Directed cases cover single beats, slow grants, FIFO back-pressure, reset abort and wrap.
`timescale 1ns/1ps
module tb_jtag_l2_burst_adapter;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] SIZE  = 32'h0008_0000;
`ifdef JTAG_L2_ADDR_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [31:0] wdata_i;
    logic        rdata_valid_o;
    logic        rdata_ready_i;
    logic [31:0] rdata_o;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic        l2_req_o;
    logic        l2_gnt_i;
    logic [31:0] l2_addr_o;
    logic        l2_we_o;
    logic [3:0]  l2_be_o;
    logic [31:0] l2_wdata_o;
    logic        l2_rvalid_i;
    logic [31:0] l2_rdata_i;

    jtag_l2_burst_adapter #(
        .ADDR_W       (32),
        .RD_FIFO_DEPTH(DEPTH),
        .L2_BASE      (BASE),
        .L2_SIZE      (SIZE)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_len_i    (cmd_len_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .wdata_i      (wdata_i),
        .rdata_valid_o(rdata_valid_o),
        .rdata_ready_i(rdata_ready_i),
        .rdata_o      (rdata_o),
        .resp_valid_o (resp_valid_o),
        .resp_err_o   (resp_err_o),
        .l2_req_o     (l2_req_o),
        .l2_gnt_i     (l2_gnt_i),
        .l2_addr_o    (l2_addr_o),
        .l2_we_o      (l2_we_o),
        .l2_be_o      (l2_be_o),
        .l2_wdata_o   (l2_wdata_o),
        .l2_rvalid_i  (l2_rvalid_i),
        .l2_rdata_i   (l2_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } req_t;

    req_t        exp_req[$];
    logic [31:0] exp_rd[$];
    logic        exp_resp[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    int          errors   = 0;
    int          checks   = 0;
    int          gcnt     = 0;
    int          gnt_mode = 0;
    int          wait_cnt = 0;
    bit          hold     = 1'b0;
    bit          rv_pend  = 1'b0;
    logic [31:0] rv_data  = 32'h0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
    endfunction

    function automatic bit cmd_err(input logic [31:0] addr, input int len);
        longint unsigned b;
        longint unsigned e;
        b = 64'(addr);
        e = b + 64'(4 * (len + 1));
        return CHK_EN && ((addr[1:0] != 2'b00) || (b < 64'(BASE)) ||
                          (e > 64'(BASE) + 64'(SIZE)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    // TCDM slave: grant policy, storage and 1-cycle read return.
    always @(posedge clk) begin
        #1;
        l2_rvalid_i = rv_pend;
        l2_rdata_i  = rv_pend ? rv_data : $urandom;
        rv_pend     = 1'b0;
        case (gnt_mode)
            0:       l2_gnt_i = ($urandom_range(0, 9) < 7);
            1:       l2_gnt_i = 1'b1;
            default: l2_gnt_i = (wait_cnt >= 2);
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && l2_req_o && l2_gnt_i) begin
            if (l2_we_o) begin
                slv_mem[l2_addr_o] = l2_wdata_o;
            end else begin
                rv_pend = 1'b1;
                rv_data = slv_rd(l2_addr_o);
            end
            wait_cnt = 0;
        end else if (rst_n && l2_req_o) begin
            wait_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        rdata_ready_i = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: every observed transfer is matched against the head of its queue.
    always @(negedge clk) begin : mon
        req_t        e;
        logic [31:0] d;
        logic        r;
        if (rst_n) begin
            if (l2_req_o && l2_gnt_i) begin
                gcnt++;
                if (exp_req.size() == 0) begin
                    fail("unexpected_req");
                end else begin
                    e = exp_req.pop_front();
                    chk("req_addr", l2_addr_o, e.addr);
                    chk1("req_we", l2_we_o, e.we);
                    chk("req_be", 32'(l2_be_o), 32'hF);
                    if (e.we) begin
                        chk("req_wdata", l2_wdata_o, e.data);
                    end
                end
            end
            if (rdata_valid_o && rdata_ready_i) begin
                if (exp_rd.size() == 0) begin
                    fail("unexpected_rdata");
                end else begin
                    d = exp_rd.pop_front();
                    chk("rdata", rdata_o, d);
                end
            end
            if (resp_valid_o) begin
                if (exp_resp.size() == 0) begin
                    fail("unexpected_resp");
                end else begin
                    r = exp_resp.pop_front();
                    chk1("resp_err", resp_err_o, r);
                end
            end
        end
    end

    task automatic burst(input bit we, input logic [31:0] addr, input int len,
                         input bit use_d0, input logic [31:0] d0);
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] beats[$];
        bit          err;
        req_t        r;
        int          n;
        err = cmd_err(addr, len);
        a   = addr & 32'hFFFF_FFFC;
        for (int i = 0; i <= len; i++) begin
            d = (use_d0 && i == 0) ? d0 : $urandom;
            beats.push_back(d);
            if (!err) begin
                r.addr = a;
                r.we   = we;
                r.data = we ? d : 32'h0;
                exp_req.push_back(r);
                if (we) ref_mem[a] = d;
            end
            if (!we) exp_rd.push_back(err ? 32'hDEAD_BEEF : ref_rd(a));
            a = a + 32'd4;
        end
        exp_resp.push_back(err);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_len_i   = 8'(len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready_o && n < 200);
        if (!cmd_ready_o) fail("cmd_accept_timeout");
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
        if (we) begin
            foreach (beats[i]) begin
                wdata_valid_i = 1'b1;
                wdata_i       = beats[i];
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!wdata_ready_o && n < 200);
                if (!wdata_ready_o) fail("wdata_timeout");
                @(posedge clk);
                #1;
            end
            wdata_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_req.size() != 0 || exp_rd.size() != 0 || exp_resp.size() != 0)
               && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 3000) begin
            fail("drain_timeout");
            exp_req.delete();
            exp_rd.delete();
            exp_resp.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          g0;
        int          n;
        bit          we;
        logic [31:0] a;
        rst_n         = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_we_i      = 1'b0;
        cmd_addr_i    = 32'h0;
        cmd_len_i     = 8'h0;
        wdata_valid_i = 1'b0;
        wdata_i       = 32'h0;
        rdata_ready_i = 1'b0;
        l2_gnt_i      = 1'b0;
        l2_rvalid_i   = 1'b0;
        l2_rdata_i    = 32'h0;

        repeat (2) @(negedge clk);
        chk1("rst_cmd_ready", cmd_ready_o, 1'b0);
        chk1("rst_req", l2_req_o, 1'b0);
        chk1("rst_rdata_valid", rdata_valid_o, 1'b0);
        chk1("rst_resp_valid", resp_valid_o, 1'b0);
        chk1("rst_wdata_ready", wdata_ready_o, 1'b0);
        chk("rst_be", 32'(l2_be_o), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("idle_cmd_ready", cmd_ready_o, 1'b1);
        @(posedge clk);
        #1;

        gnt_mode = 1;
        burst(1'b1, 32'h0, 0, 1'b1, 32'hABBA_ABBA);
        drain();
        burst(1'b0, 32'h0, 0, 1'b0, 32'h0);
        drain();

        gnt_mode = 2;
        burst(1'b1, 32'h100, 3, 1'b0, 32'h0);
        drain();
        gnt_mode = 0;
        burst(1'b0, 32'h100, 3, 1'b0, 32'h0);
        drain();

        gnt_mode = 1;
        hold     = 1'b1;
        g0       = gcnt;
        burst(1'b0, 32'h200, 7, 1'b0, 32'h0);
        repeat (20) @(negedge clk);
        #1;
        chk("t3_grants", gcnt - g0, DEPTH);
        chk1("t3_req_stalled", l2_req_o, 1'b0);
        hold = 1'b0;
        drain();

        hold = 1'b1;
        g0   = gcnt;
        burst(1'b0, 32'h300, 7, 1'b0, 32'h0);
        n = 0;
        while ((gcnt - g0) < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t4_grants", gcnt - g0, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_req.delete();
        exp_rd.delete();
        exp_resp.delete();
        @(negedge clk);
        chk1("t4_rst_req", l2_req_o, 1'b0);
        chk1("t4_rst_cmd_ready", cmd_ready_o, 1'b0);
        chk1("t4_rst_rdata_valid", rdata_valid_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rv_pend = 1'b1;
        rv_data = 32'h1234_5678;
        @(negedge clk);
        chk1("t4_req_after", l2_req_o, 1'b0);
        chk1("t4_cmd_ready_after", cmd_ready_o, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk1("t4_no_rdata", rdata_valid_o, 1'b0);
            chk1("t4_no_resp", resp_valid_o, 1'b0);
        end
        hold = 1'b0;
        @(posedge clk);
        #1;

`ifndef JTAG_L2_ADDR_CHECK_EN
        gnt_mode = 0;
        burst(1'b0, 32'hFFFF_FFFC, 1, 1'b0, 32'h0);
        drain();
`endif

        gnt_mode = 0;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            burst(we, a, $urandom_range(0, 7), 1'b0, 32'h0);
            drain();
        end

`ifdef JTAG_L2_ADDR_CHECK_EN
        g0 = gcnt;
        burst(1'b0, BASE + SIZE - 32'd4, 1, 1'b0, 32'h0);
        drain();
        burst(1'b1, 32'h2, 0, 1'b0, 32'h0);
        drain();
        chk("t6_no_req", gcnt - g0, 0);
`endif

        drain();
        chk("end_queues", exp_req.size() + exp_rd.size() + exp_resp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
